// File: rtl/operator_sequencer_pkg.sv
// Shared types for the operator sequencer: operator IDs, queued config writes, FSM states.
package operator_sequencer_pkg;

  localparam int NUM_VOICE_OPERATORS = 24;
  typedef logic [4:0] VoiceOperatorID_t;

  localparam VoiceOperatorID_t LAST_OP_ID = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);

  typedef struct packed {
    VoiceOperatorID_t addr;
    logic [1:0]       select;
    logic [7:0]       data;
  } AlgorithmCfgWrite_t;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} SeqState_t;

endpackage

// File: rtl/operator_sequencer_if.sv
// Frame-control, operator-stream and config-write signals of operator_sequencer.
// OPERATOR_SEQUENCER_MISS_COUNT_EN adds o_TickMissCount.
interface operator_sequencer_if;
  import operator_sequencer_pkg::*;

  logic             i_Enable;
  logic             i_SampleTick;
  VoiceOperatorID_t o_VoiceOperator;
  logic             o_VoiceOperatorValid;
  logic             o_FrameBusy;
  logic             o_FrameDone;
  logic             o_TickMissed;
  logic             i_CfgValid;
  logic             o_CfgReady;
  VoiceOperatorID_t i_CfgAddr;
  logic [1:0]       i_CfgSelect;
  logic [7:0]       i_CfgData;
  logic [1:0]       o_AlgorithmWriteEnable;
  VoiceOperatorID_t o_AlgorithmWriteAddr;
  logic [7:0]       o_AlgorithmWriteData;
`ifdef OPERATOR_SEQUENCER_MISS_COUNT_EN
  logic [15:0]      o_TickMissCount;
`endif

  modport master (
`ifdef OPERATOR_SEQUENCER_MISS_COUNT_EN
    input  o_TickMissCount,
`endif
    output i_Enable, i_SampleTick, i_CfgValid, i_CfgAddr, i_CfgSelect, i_CfgData,
    input  o_VoiceOperator, o_VoiceOperatorValid, o_FrameBusy, o_FrameDone, o_TickMissed,
    input  o_CfgReady, o_AlgorithmWriteEnable, o_AlgorithmWriteAddr, o_AlgorithmWriteData
  );

  modport slave (
`ifdef OPERATOR_SEQUENCER_MISS_COUNT_EN
    output o_TickMissCount,
`endif
    input  i_Enable, i_SampleTick, i_CfgValid, i_CfgAddr, i_CfgSelect, i_CfgData,
    output o_VoiceOperator, o_VoiceOperatorValid, o_FrameBusy, o_FrameDone, o_TickMissed,
    output o_CfgReady, o_AlgorithmWriteEnable, o_AlgorithmWriteAddr, o_AlgorithmWriteData
  );

endinterface

// File: rtl/operator_sequencer_config_fifo.sv
// Small synchronous FIFO; full/empty are registered, so a pop never frees a slot for a same-cycle push.
module config_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (count_d == (AW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/operator_sequencer.sv
// Sweeps operator IDs into the modulator once per sample frame and applies queued config writes between frames.
// Build option OPERATOR_SEQUENCER_MISS_COUNT_EN adds a saturating missed-tick counter.
module operator_sequencer
  import operator_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES   = 8,
  parameter int CFG_FIFO_DEPTH = 4
) (
  input logic               i_Clock,
  input logic               i_Reset_n,
  operator_sequencer_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  SeqState_t          state_q, state_d;
  VoiceOperatorID_t   id_q, id_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               valid_q, valid_d, busy_q, busy_d;
  logic               done_q, done_d, missed_q, missed_d;
  logic [1:0]         we_q, we_d;
  VoiceOperatorID_t   waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               start, cfg_pop, cfg_full, cfg_empty;
  AlgorithmCfgWrite_t cfg_in, cfg_head;

  assign cfg_in = '{addr: bus.i_CfgAddr, select: bus.i_CfgSelect, data: bus.i_CfgData};

  config_fifo #(.DEPTH(CFG_FIFO_DEPTH), .T(AlgorithmCfgWrite_t)) u_cfg_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .push      (bus.i_CfgValid),
    .push_data (cfg_in),
    .pop       (cfg_pop),
    .pop_data  (cfg_head),
    .full      (cfg_full),
    .empty     (cfg_empty)
  );

  always_comb begin
    start    = bus.i_SampleTick && bus.i_Enable;
    state_d  = state_q;
    id_d     = '0;
    drain_d  = drain_q;
    done_d   = 1'b0;
    missed_d = 1'b0;
    cfg_pop  = 1'b0;
    we_d     = '0;
    waddr_d  = '0;
    wdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        // A start tick wins over a pending config pop in the same cycle.
        if (start) begin
          state_d = SWEEP;
        end else if (!cfg_empty) begin
          cfg_pop = 1'b1;
          we_d    = cfg_head.select;
          waddr_d = cfg_head.addr;
          wdata_d = cfg_head.data;
        end
      end
      SWEEP: begin
        missed_d = start;
        if (id_q == LAST_OP_ID) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          id_d = id_q + 1'b1;
        end
      end
      DRAIN: begin
        missed_d = start;
        if (drain_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SWEEP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      id_q     <= '0;
      drain_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      drain_q  <= drain_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      missed_q <= missed_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.o_VoiceOperator        = id_q;
  assign bus.o_VoiceOperatorValid   = valid_q;
  assign bus.o_FrameBusy            = busy_q;
  assign bus.o_FrameDone            = done_q;
  assign bus.o_TickMissed           = missed_q;
  assign bus.o_CfgReady             = !cfg_full;
  assign bus.o_AlgorithmWriteEnable = we_q;
  assign bus.o_AlgorithmWriteAddr   = waddr_q;
  assign bus.o_AlgorithmWriteData   = wdata_q;

`ifdef OPERATOR_SEQUENCER_MISS_COUNT_EN
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (missed_d && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) miss_cnt_q <= '0;
    else            miss_cnt_q <= miss_cnt_d;
  end

  assign bus.o_TickMissCount = miss_cnt_q;
`endif

endmodule
